// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path: FSM states and framebuffer geometry.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int FB_DEPTH  = H_RES_DEF * V_RES_DEF;

endpackage

// File: rtl/ov7670_fb_writer_edge_detect.sv
// Registered edge detector: keeps the previous sample and flags rise/fall against it.
module ov7670_fb_writer_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;
    assign fall = ~sig & sig_d;

endmodule

// File: rtl/ov7670_fb_writer.sv
// OV7670 byte stream to RGB565 framebuffer writer; frame-aligned, addresses clamped to the buffer.
module ov7670_fb_writer
    import ov7670_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              busy
);

    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(H_RES);
    localparam logic [YW-1:0]     Y_MAX     = YW'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    state_t state, state_next;

    logic              vsync_rise, vsync_fall;
    logic              href_rise, href_fall;
    logic              start_frame, frame_end;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic [7:0]        hi_byte;
    logic              cur_phase, byte_ok, in_window;

    ov7670_fb_writer_edge_detect u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (vsync),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    ov7670_fb_writer_edge_detect u_href_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_rise && capture_en) state_next = SYNC;
            end
            SYNC: begin
                if (vsync_fall) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    frame_end  = 1'b1;
                    state_next = capture_en ? SYNC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A byte arriving on the first href cycle of a line is always a high byte.
    assign cur_phase = phase & ~href_rise;
    assign byte_ok   = (state == ACTIVE) && href && !vsync_rise;
    assign in_window = (x < X_MAX) && (y < Y_MAX);
    assign busy      = (state == ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= frame_end;
            if (start_frame) begin
                x         <= '0;
                y         <= '0;
                line_base <= '0;
                wAddr     <= '0;
                phase     <= 1'b0;
            end else if ((state == ACTIVE) && !vsync_rise) begin
                if (href_fall) begin
                    x     <= '0;
                    phase <= 1'b0;
                    if (y < Y_MAX) begin
                        y         <= y + 1'b1;
                        line_base <= line_base + LINE_STEP;
                    end
                end else if (byte_ok) begin
                    if (!cur_phase) begin
                        hi_byte <= data;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        // x stops at H_RES so an overlong line can never wrap back into range.
                        if (in_window) begin
                            we    <= 1'b1;
                            wData <= {hi_byte, data};
                            wAddr <= line_base + ADDR_W'(x);
                            x     <= x + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Directed bench for ov7670_fb_writer: frame vectors against an address/data scoreboard plus corner sequences.
module tb_ov7670_fb_writer;

    localparam int H  = 320;
    localparam int V  = 4;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          frame_done;
    logic          busy;

    ov7670_fb_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lines;
        int          px;
        bit          odd;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          exp_we;
        int          exp_last;
    } vec_t;

    vec_t vecs[5];

    int          exp_addr [8192];
    logic [15:0] exp_data [8192];
    int          wr_idx = 0;

    int rd_idx    = 0;
    int n_we      = 0;
    int n_bad     = 0;
    int n_done    = 0;
    int n_busy    = 0;
    int last_addr = -1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always @(negedge clk) begin
        if (busy) n_busy <= n_busy + 1;
        if (frame_done) n_done <= n_done + 1;
        if (we) begin
            n_we      <= n_we + 1;
            last_addr <= int'(wAddr);
            if (rd_idx >= wr_idx) begin
                n_bad <= n_bad + 1;
            end else begin
                if (exp_addr[rd_idx] != int'(wAddr) || exp_data[rd_idx] != wData)
                    n_bad <= n_bad + 1;
                rd_idx <= rd_idx + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        @(negedge clk);
        vsync = v;
        href  = h;
        data  = d;
    endtask

    task automatic push(input int a, input logic [15:0] d);
        exp_addr[wr_idx] = a;
        exp_data[wr_idx] = d;
        wr_idx++;
    endtask

    task automatic send_line(input int px, input bit odd, input logic [7:0] hi,
                             input logic [7:0] lo, input int line, input bit cap);
        for (int p = 0; p < px; p++) begin
            step(1'b0, 1'b1, hi);
            if (cap && p < H && line < V) push(line * H + p, {hi, lo});
            step(1'b0, 1'b1, lo);
        end
        if (odd) step(1'b0, 1'b1, 8'h99);
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_rise();
        repeat (4) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic frame_fall();
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_we, b_bad, b_done, b_busy;

        vecs[0] = '{lines: 4, px: 320, odd: 1'b0, hi: 8'hA5, lo: 8'h5A, exp_we: 1280, exp_last: 1279};
        vecs[1] = '{lines: 3, px: 330, odd: 1'b0, hi: 8'h12, lo: 8'h34, exp_we: 960,  exp_last: 959};
        vecs[2] = '{lines: 2, px: 320, odd: 1'b1, hi: 8'hC3, lo: 8'h3C, exp_we: 640,  exp_last: 639};
        vecs[3] = '{lines: 6, px: 320, odd: 1'b0, hi: 8'h0F, lo: 8'hF0, exp_we: 1280, exp_last: 1279};
        vecs[4] = '{lines: 1, px: 5,   odd: 1'b0, hi: 8'h81, lo: 8'h7E, exp_we: 5,    exp_last: 4};

        reset = 1'b1; capture_en = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_wAddr", int'(wAddr), 0);
        check("rst_wData", int'(wData), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Capture one line, then reset mid-frame; the rest of that frame must be ignored.
        frame_rise();
        frame_fall();
        send_line(320, 1'b0, 8'h66, 8'h77, 0, 1'b1);
        check("pre_reset_writes", n_we, 320);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("midreset_busy", int'(busy), 0);
        check("midreset_wAddr", int'(wAddr), 0);
        reset = 1'b0;
        b_we = n_we; b_done = n_done;
        send_line(320, 1'b0, 8'hA5, 8'h5A, 1, 1'b0);
        send_line(320, 1'b0, 8'hA5, 8'h5A, 2, 1'b0);
        frame_rise();
        check("partial_frame_no_we", n_we - b_we, 0);
        check("partial_frame_no_done", n_done - b_done, 0);
        frame_fall();

        for (int i = 0; i < 5; i++) begin
            b_we = n_we; b_bad = n_bad; b_done = n_done;
            for (int l = 0; l < vecs[i].lines; l++)
                send_line(vecs[i].px, vecs[i].odd, vecs[i].hi, vecs[i].lo, l, 1'b1);
            check($sformatf("vec%0d_busy", i), int'(busy), 1);
            frame_rise();
            check($sformatf("vec%0d_we_count", i), n_we - b_we, vecs[i].exp_we);
            check($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].exp_last);
            check($sformatf("vec%0d_scoreboard_errs", i), n_bad - b_bad, 0);
            check($sformatf("vec%0d_pending", i), wr_idx - rd_idx, 0);
            check($sformatf("vec%0d_frame_done", i), n_done - b_done, 1);
            frame_fall();
        end

        // Single pixel latency, then a vsync rise colliding with a second byte.
        b_we = n_we; b_bad = n_bad; b_done = n_done;
        push(0, 16'hF800);
        step(1'b0, 1'b1, 8'hF8);
        step(1'b0, 1'b1, 8'h00);
        check("no_we_after_hi", int'(we), 0);
        @(posedge clk); #1;
        check("f800_we", int'(we), 1);
        check("f800_wData", int'(wData), 16'hF800);
        check("f800_wAddr", int'(wAddr), 0);
        step(1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("we_one_cycle", int'(we), 0);
        step(1'b0, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        @(posedge clk); #1;
        check("vsync_wins_no_we", int'(we), 0);
        check("vsync_wins_done", int'(frame_done), 1);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("collide_we_count", n_we - b_we, 1);
        check("collide_scoreboard", n_bad - b_bad, 0);
        check("collide_done_count", n_done - b_done, 1);
        frame_fall();

        // capture_en dropped mid-frame: this frame completes, then capture stops.
        b_we = n_we; b_bad = n_bad; b_done = n_done;
        send_line(320, 1'b0, 8'h3E, 8'hE3, 0, 1'b1);
        capture_en = 1'b0;
        send_line(320, 1'b0, 8'h3E, 8'hE3, 1, 1'b1);
        frame_rise();
        check("capoff_frame_we", n_we - b_we, 640);
        check("capoff_frame_done", n_done - b_done, 1);
        check("capoff_scoreboard", n_bad - b_bad, 0);
        b_we = n_we; b_done = n_done; b_busy = n_busy;
        frame_fall();
        send_line(320, 1'b0, 8'hAA, 8'h55, 0, 1'b0);
        frame_rise();
        frame_fall();
        send_line(320, 1'b0, 8'hAA, 8'h55, 0, 1'b0);
        capture_en = 1'b1;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check("idle_no_we", n_we - b_we, 0);
        check("idle_no_done", n_done - b_done, 0);
        check("idle_busy_low", n_busy - b_busy, 0);
        frame_rise();
        frame_fall();
        b_we = n_we; b_bad = n_bad; b_done = n_done;
        send_line(4, 1'b0, 8'h5C, 8'hA3, 0, 1'b1);
        frame_rise();
        check("resume_we", n_we - b_we, 4);
        check("resume_last_addr", last_addr, 3);
        check("resume_scoreboard", n_bad - b_bad, 0);
        check("resume_done", n_done - b_done, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
